conv1d_job_sequencer: RTL

- Sequences the conv1d CFU command port for a multi-position job.
- For each output position it:
  - writes the ring start index (cmd 8) and starts the computation (cmd 6);
  - polls for completion (cmd 9) and reads the quantized result (cmd 7);
  - streams the result out through a valid/ready handshake.
- Between positions it hands the command port to the host so the next input column can be written (cmds 1–5, 12–17).
- Sits between the CPU custom-instruction decode and conv1d; it is the only driver of the conv1d port.

---
 rtl/conv1d_pkg.sv | 33 +++
 rtl/conv1d_port_mux.sv | 42 ++++
 rtl/conv1d_job_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/conv1d_pkg.sv
// rtl/conv1d_pkg.sv - conv1d command codes, sequencer states and ring depth
package conv1d_pkg;

  localparam int KERNEL_LENGTH = 8;

  localparam logic [6:0] CMD_WRITE_INPUT  = 7'd1;
  localparam logic [6:0] CMD_WRITE_FILTER = 7'd2;
  localparam logic [6:0] CMD_INPUT_OFFSET = 7'd3;
  localparam logic [6:0] CMD_INPUT_DEPTH  = 7'd5;
  localparam logic [6:0] CMD_START        = 7'd6;
  localparam logic [6:0] CMD_GET_ACC      = 7'd7;
  localparam logic [6:0] CMD_START_X      = 7'd8;
  localparam logic [6:0] CMD_DONE         = 7'd9;
  localparam logic [6:0] CMD_BIAS         = 7'd12;
  localparam logic [6:0] CMD_OUT_MULT     = 7'd13;
  localparam logic [6:0] CMD_OUT_SHIFT    = 7'd14;
  localparam logic [6:0] CMD_ACT_MIN      = 7'd15;
  localparam logic [6:0] CMD_ACT_MAX      = 7'd16;
  localparam logic [6:0] CMD_OUT_OFFSET   = 7'd17;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SET_X,
    ST_START,
    ST_POLL_ISSUE,
    ST_POLL_CHECK,
    ST_READ_ISSUE,
    ST_READ_CAPTURE,
    ST_OUT,
    ST_WAIT_COL
  } seq_state_t;

endpackage

// File: rtl/conv1d_port_mux.sv
// rtl/conv1d_port_mux.sv - registered 2:1 grant mux between host and sequencer commands
module conv1d_port_mux (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_sel,
  input  logic        host_en,
  input  logic [6:0]  host_cmd,
  input  logic [31:0] host_inp0,
  input  logic [31:0] host_inp1,
  input  logic        seq_en,
  input  logic [6:0]  seq_cmd,
  input  logic [31:0] seq_inp0,
  input  logic [31:0] seq_inp1,
  output logic        cu_en,
  output logic [6:0]  cu_cmd,
  output logic [31:0] cu_inp0,
  output logic [31:0] cu_inp1
);

  // Sequencer operands are only loaded with a command, so idle cycles hold the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cu_en   <= 1'b0;
      cu_cmd  <= 7'd0;
      cu_inp0 <= 32'd0;
      cu_inp1 <= 32'd0;
    end else if (host_sel) begin
      cu_en   <= host_en;
      cu_cmd  <= host_cmd;
      cu_inp0 <= host_inp0;
      cu_inp1 <= host_inp1;
    end else begin
      cu_en <= seq_en;
      if (seq_en) begin
        cu_cmd  <= seq_cmd;
        cu_inp0 <= seq_inp0;
        cu_inp1 <= seq_inp1;
      end
    end
  end

endmodule

// File: rtl/conv1d_job_sequencer.sv
// rtl/conv1d_job_sequencer.sv - runs a multi-position conv1d job over the CFU command port
module conv1d_job_sequencer #(
  parameter int KERNEL_LENGTH = conv1d_pkg::KERNEL_LENGTH,
  parameter int POS_W         = 16,
  parameter int POLL_TIMEOUT  = 4096
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             host_en,
  input  logic [6:0]                       host_cmd,
  input  logic [31:0]                      host_inp0,
  input  logic [31:0]                      host_inp1,
  output logic [31:0]                      host_ret,
  output logic                             host_busy,
  input  logic                             job_start,
  input  logic [POS_W-1:0]                 job_positions,
  input  logic [$clog2(KERNEL_LENGTH)-1:0] job_start_x,
  output logic                             job_busy,
  output logic                             job_done,
  output logic                             job_err,
  output logic                             col_req,
  input  logic                             col_done,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [31:0]                      res_data,
  output logic [POS_W-1:0]                 res_index,
  output logic                             cu_en,
  output logic [6:0]                       cu_cmd,
  output logic [31:0]                      cu_inp0,
  output logic [31:0]                      cu_inp1,
  input  logic [31:0]                      cu_ret
);
  import conv1d_pkg::*;

  localparam int XW = $clog2(KERNEL_LENGTH);
  localparam int CW = $clog2(POLL_TIMEOUT + 1);

  seq_state_t       state;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] positions_q;
  logic [XW-1:0]    start_x_q;
  logic [CW-1:0]    poll_cnt;

  logic          launch, col_go, poll_hit, poll_again, host_sel;
  logic          seq_en;
  logic [6:0]    seq_cmd;
  logic [31:0]   seq_inp1;
  logic [XW-1:0] next_x;

  assign launch     = (state == ST_IDLE) && job_start && (job_positions != '0);
  assign col_go     = (state == ST_WAIT_COL) && col_done;
  assign poll_hit   = (state == ST_POLL_CHECK) && cu_ret[0];
  assign poll_again = (state == ST_POLL_CHECK) && !cu_ret[0] && (poll_cnt != CW'(POLL_TIMEOUT));
  assign host_sel   = ((state == ST_IDLE) && !launch) || ((state == ST_WAIT_COL) && !col_done);
  assign next_x     = start_x_q + pos[XW-1:0];

  // The mux registers its input, so requests are raised one cycle ahead of the
  // state that owns the command; that keeps cu_ret aligned with POLL_CHECK.
  always_comb begin
    seq_en   = 1'b0;
    seq_cmd  = CMD_DONE;
    seq_inp1 = 32'd0;
    if (launch) begin
      seq_en   = 1'b1;
      seq_cmd  = CMD_START_X;
      seq_inp1 = 32'(job_start_x);
    end else if (col_go) begin
      seq_en   = 1'b1;
      seq_cmd  = CMD_START_X;
      seq_inp1 = 32'(next_x);
    end else if (state == ST_SET_X) begin
      seq_en  = 1'b1;
      seq_cmd = CMD_START;
    end else if ((state == ST_START) || poll_again) begin
      seq_en  = 1'b1;
      seq_cmd = CMD_DONE;
    end else if (poll_hit) begin
      seq_en  = 1'b1;
      seq_cmd = CMD_GET_ACC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pos         <= '0;
      positions_q <= '0;
      start_x_q   <= '0;
      poll_cnt    <= '0;
      job_done    <= 1'b0;
      job_err     <= 1'b0;
      res_data    <= 32'd0;
      res_index   <= '0;
    end else begin
      job_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (job_start) begin
            job_err <= 1'b0;
            if (job_positions == '0) begin
              job_done <= 1'b1;
            end else begin
              pos         <= '0;
              poll_cnt    <= '0;
              positions_q <= job_positions;
              start_x_q   <= job_start_x;
              state       <= ST_SET_X;
            end
          end
        end
        ST_SET_X: state <= ST_START;
        ST_START: state <= ST_POLL_ISSUE;
        ST_POLL_ISSUE: begin
          poll_cnt <= poll_cnt + CW'(1);
          state    <= ST_POLL_CHECK;
        end
        ST_POLL_CHECK: begin
          if (cu_ret[0]) begin
            state <= ST_READ_ISSUE;
          end else if (poll_cnt == CW'(POLL_TIMEOUT)) begin
            job_err  <= 1'b1;
            job_done <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            state <= ST_POLL_ISSUE;
          end
        end
        ST_READ_ISSUE: state <= ST_READ_CAPTURE;
        ST_READ_CAPTURE: begin
          res_data  <= cu_ret;
          res_index <= pos;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (res_ready) begin
            if (pos + POS_W'(1) == positions_q) begin
              job_done <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              pos   <= pos + POS_W'(1);
              state <= ST_WAIT_COL;
            end
          end
        end
        ST_WAIT_COL: begin
          if (col_done) begin
            poll_cnt <= '0;
            state    <= ST_SET_X;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign res_valid = (state == ST_OUT);
  assign col_req   = (state == ST_WAIT_COL);
  assign job_busy  = (state != ST_IDLE);
  assign host_busy = !((state == ST_IDLE) || (state == ST_WAIT_COL));
  assign host_ret  = cu_ret;

  conv1d_port_mux u_port_mux (
    .clk       (clk),
    .rst_n     (rst_n),
    .host_sel  (host_sel),
    .host_en   (host_en),
    .host_cmd  (host_cmd),
    .host_inp0 (host_inp0),
    .host_inp1 (host_inp1),
    .seq_en    (seq_en),
    .seq_cmd   (seq_cmd),
    .seq_inp0  (32'd0),
    .seq_inp1  (seq_inp1),
    .cu_en     (cu_en),
    .cu_cmd    (cu_cmd),
    .cu_inp0   (cu_inp0),
    .cu_inp1   (cu_inp1)
  );

endmodule
